// File: rtl/multicycle_ctrl.sv
// Multi-cycle RISC-V style control FSM: FETCH/DECODE/EXEC/MEM/WB (+HALT).
// The instruction class, alu_cc and alu_src are captured in DECODE and held
// until the instruction retires. Strobes decode only from registered state;
// the single exception is pc_write/ir_write, which also depend on the run input.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN makes an illegal opcode trap
// into HALT. When the macro is undefined, an illegal opcode retires as a NOP.
module multicycle_ctrl #(
  parameter int unsigned ALU_CC_W = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                mem2reg,
  output logic                alu_src,
  output logic                mem_write,
  output logic                mem_read,
  output logic [ALU_CC_W-1:0] alu_cc,
  output logic [2:0]          state,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  typedef enum logic [1:0] {ClsR, ClsI, ClsLoad, ClsStore} cls_e;

  localparam logic [3:0] CcAdd = 4'b0010;
  localparam logic [3:0] CcSub = 4'b0110;
  localparam logic [3:0] CcAnd = 4'b0000;
  localparam logic [3:0] CcOr  = 4'b0001;
  localparam logic [3:0] CcXor = 4'b0011;
  localparam logic [3:0] CcSlt = 4'b0111;
  localparam logic [3:0] CcSll = 4'b1000;
  localparam logic [3:0] CcSrl = 4'b1001;
  localparam logic [3:0] CcSra = 4'b1010;

  state_e                state_q;
  cls_e                  cls_q;
  logic [ALU_CC_W-1:0]   alu_cc_q;
  logic                  alu_src_q;
  logic [CNT_W-1:0]      retired_q;

  cls_e                  dec_cls;
  logic                  dec_legal;
  logic [3:0]            dec_cc;

  // Classify the opcode and derive the ALU operation; consumed only in DECODE.
  always_comb begin
    dec_cls   = ClsR;
    dec_legal = 1'b1;
    dec_cc    = CcAdd;
    unique case (opcode)
      7'b0110011: dec_cls = ClsR;
      7'b0010011: dec_cls = ClsI;
      7'b0000011: dec_cls = ClsLoad;
      7'b0100011: dec_cls = ClsStore;
      default:    dec_legal = 1'b0;
    endcase
    if (dec_legal && (dec_cls == ClsR || dec_cls == ClsI)) begin
      case (funct3)
        // Only R-type distinguishes SUB; for I-ALU, funct3=000 is always ADDI.
        3'b000:  dec_cc = (dec_cls == ClsR && funct7 == 7'b0100000) ? CcSub : CcAdd;
        3'b111:  dec_cc = CcAnd;
        3'b110:  dec_cc = CcOr;
        3'b100:  dec_cc = CcXor;
        3'b010:  dec_cc = CcSlt;
        3'b001:  dec_cc = CcSll;
        3'b101: begin
          if (dec_cls == ClsR) dec_cc = (funct7 == 7'b0100000) ? CcSra : CcSrl;
          else                 dec_cc = funct7[5] ? CcSra : CcSrl;
        end
        default: dec_cc = CcAdd;
      endcase
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
`endif

  // Main FSM: state, captured instruction info and retired counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      cls_q     <= ClsR;
      alu_cc_q  <= ALU_CC_W'(CcAdd);
      alu_src_q <= 1'b0;
      retired_q <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        StFetch: begin
          if (run) state_q <= StDecode;
        end
        StDecode: begin
          cls_q     <= dec_cls;
          alu_cc_q  <= ALU_CC_W'(dec_cc);
          alu_src_q <= (dec_cls != ClsR);
          if (dec_legal) begin
            state_q <= StExec;
          end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_q   <= StHalt;
            illegal_q <= 1'b1;
`else
            // Illegal opcode retires as a NOP.
            state_q   <= StFetch;
            retired_q <= retired_q + CNT_W'(1);
`endif
          end
        end
        StExec: begin
          state_q <= (cls_q == ClsLoad || cls_q == ClsStore) ? StMem : StWb;
        end
        StMem: begin
          if (cls_q == ClsLoad) begin
            state_q <= StWb;
          end else begin
            state_q   <= StFetch;
            retired_q <= retired_q + CNT_W'(1);
          end
        end
        StWb: begin
          state_q   <= StFetch;
          retired_q <= retired_q + CNT_W'(1);
        end
        StHalt: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_q <= StHalt;
`else
          state_q <= StFetch;
`endif
        end
        default: state_q <= StFetch;
      endcase
    end
  end

  // Strobes decoded from registered state (plus run for the fetch strobes).
  assign pc_write  = (state_q == StFetch) && run;
  assign ir_write  = (state_q == StFetch) && run;
  assign mem_read  = (state_q == StMem) && (cls_q == ClsLoad);
  assign mem_write = (state_q == StMem) && (cls_q == ClsStore);
  assign reg_write = (state_q == StWb);
  assign mem2reg   = (state_q == StWb) && (cls_q == ClsLoad);
  assign alu_src   = alu_src_q;
  assign alu_cc    = alu_cc_q;
  assign state     = state_q;
  assign retired   = retired_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal   = illegal_q;
`else
  assign illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl. A second instance with a
// 3-bit retired counter exercises counter wrap in few cycles.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset, run;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       pc_write, ir_write, reg_write, mem2reg, alu_src, mem_write, mem_read;
  logic [3:0] alu_cc;
  logic [2:0] state;
  logic       illegal;
  logic [15:0] retired;

  logic       s_pc_write, s_ir_write, s_reg_write, s_mem2reg, s_alu_src;
  logic       s_mem_write, s_mem_read, s_illegal;
  logic [3:0] s_alu_cc;
  logic [2:0] s_state;
  logic [2:0] s_retired;

  int checks = 0;
  int failures = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.ALU_CC_W(4), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem2reg(mem2reg), .alu_src(alu_src), .mem_write(mem_write), .mem_read(mem_read),
    .alu_cc(alu_cc), .state(state), .illegal(illegal), .retired(retired)
  );

  multicycle_ctrl #(.ALU_CC_W(4), .CNT_W(3)) u_small (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .pc_write(s_pc_write), .ir_write(s_ir_write),
    .reg_write(s_reg_write), .mem2reg(s_mem2reg), .alu_src(s_alu_src),
    .mem_write(s_mem_write), .mem_read(s_mem_read), .alu_cc(s_alu_cc),
    .state(s_state), .illegal(s_illegal), .retired(s_retired)
  );

  // kind: 0 R-type, 1 I-ALU, 2 LOAD, 3 STORE, 4 illegal
  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int         kind;
    logic [3:0] cc;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input int kind, input logic [3:0] cc);
    vec_t v;
    v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.kind = kind; v.cc = cc;
    return v;
  endfunction

  // Entered and left at negedge+1 with the FSM in FETCH.
  task automatic do_instr(input vec_t v);
    int seq[5];
    int n;
    case (v.kind)
      0, 1:    begin seq = '{0, 1, 2, 4, 0}; n = 4; end
      2:       begin seq = '{0, 1, 2, 3, 4}; n = 5; end
      3:       begin seq = '{0, 1, 2, 3, 0}; n = 4; end
      default: begin seq = '{0, 1, 0, 0, 0}; n = 2; end
    endcase
    opcode = v.op; funct3 = v.f3; funct7 = v.f7; run = 1'b1;
    #1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) run = 1'b0;
      chk({v.name, ".state"}, 32'(state), 32'(seq[i]));
      chk({v.name, ".pc_write"}, 32'(pc_write), 32'(i == 0));
      chk({v.name, ".ir_write"}, 32'(ir_write), 32'(i == 0));
      chk({v.name, ".mem_read"}, 32'(mem_read), 32'(seq[i] == 3 && v.kind == 2));
      chk({v.name, ".mem_write"}, 32'(mem_write), 32'(seq[i] == 3 && v.kind == 3));
      chk({v.name, ".reg_write"}, 32'(reg_write), 32'(seq[i] == 4));
      chk({v.name, ".mem2reg"}, 32'(mem2reg), 32'(seq[i] == 4 && v.kind == 2));
      chk({v.name, ".illegal"}, 32'(illegal), 32'd0);
      if (seq[i] >= 2) begin
        chk({v.name, ".alu_cc"}, 32'(alu_cc), 32'(v.cc));
        chk({v.name, ".alu_src"}, 32'(alu_src), 32'(v.kind != 0));
      end
      @(negedge clk); #1;
    end
    exp_ret++;
    chk({v.name, ".end_state"}, 32'(state), 32'd0);
    chk({v.name, ".retired"}, 32'(retired), 32'(exp_ret & 16'hFFFF));
    chk({v.name, ".retired_w3"}, 32'(s_retired), 32'(exp_ret & 7));
  endtask

  task automatic pulse_reset();
    reset = 1'b1; run = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0; exp_ret = 0;
    #1;
  endtask

  initial begin
    vec_t lw;
    vecs[0]  = mk("add",  7'b0110011, 3'b000, 7'b0000000, 0, 4'b0010);
    vecs[1]  = mk("sub",  7'b0110011, 3'b000, 7'b0100000, 0, 4'b0110);
    vecs[2]  = mk("and",  7'b0110011, 3'b111, 7'b0000000, 0, 4'b0000);
    vecs[3]  = mk("or",   7'b0110011, 3'b110, 7'b0000000, 0, 4'b0001);
    vecs[4]  = mk("xor",  7'b0110011, 3'b100, 7'b0000000, 0, 4'b0011);
    vecs[5]  = mk("slt",  7'b0110011, 3'b010, 7'b0000000, 0, 4'b0111);
    vecs[6]  = mk("sll",  7'b0110011, 3'b001, 7'b0000000, 0, 4'b1000);
    vecs[7]  = mk("srl",  7'b0110011, 3'b101, 7'b0000000, 0, 4'b1001);
    vecs[8]  = mk("sra",  7'b0110011, 3'b101, 7'b0100000, 0, 4'b1010);
    vecs[9]  = mk("addi", 7'b0010011, 3'b000, 7'b0100000, 1, 4'b0010);
    vecs[10] = mk("srli", 7'b0010011, 3'b101, 7'b0000000, 1, 4'b1001);
    vecs[11] = mk("srai", 7'b0010011, 3'b101, 7'b0100000, 1, 4'b1010);
    vecs[12] = mk("lw",   7'b0000011, 3'b010, 7'b0000000, 2, 4'b0010);
    vecs[13] = mk("sw",   7'b0100011, 3'b010, 7'b0000000, 3, 4'b0010);
    vecs[14] = mk("andi", 7'b0010011, 3'b111, 7'b1111111, 1, 4'b0000);

    reset = 1'b1; run = 1'b0; opcode = '0; funct3 = '0; funct7 = '0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst.state", 32'(state), 32'd0);
    chk("rst.alu_cc", 32'(alu_cc), 32'h2);
    chk("rst.alu_src", 32'(alu_src), 32'd0);
    chk("rst.retired", 32'(retired), 32'd0);
    chk("rst.illegal", 32'(illegal), 32'd0);
    chk("rst.strobes", 32'({pc_write, ir_write, reg_write, mem_write, mem_read, mem2reg}), 32'd0);
    @(negedge clk); reset = 1'b0; #1;

    // Stall in FETCH with run low.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("stall.state", 32'(state), 32'd0);
      chk("stall.pc_write", 32'(pc_write), 32'd0);
    end

    foreach (vecs[i]) do_instr(vecs[i]);

    // Illegal opcode.
    opcode = 7'b1111111; funct3 = '0; funct7 = '0; run = 1'b1;
    @(negedge clk); #1;
    chk("ill.decode", 32'(state), 32'd1);
    run = 1'b0;
    @(negedge clk); #1;
`ifdef CTRL_ILLEGAL_TRAP_EN
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("ill.halt_state", 32'(state), 32'd5);
      chk("ill.flag", 32'(illegal), 32'd1);
      chk("ill.retired", 32'(retired), 32'(exp_ret & 16'hFFFF));
      chk("ill.strobes", 32'({pc_write, ir_write, reg_write, mem_write, mem_read}), 32'd0);
      @(negedge clk); #1;
    end
    pulse_reset();
    chk("ill.after_rst_state", 32'(state), 32'd0);
    chk("ill.after_rst_flag", 32'(illegal), 32'd0);
`else
    exp_ret++;
    chk("ill.nop_state", 32'(state), 32'd0);
    chk("ill.flag", 32'(illegal), 32'd0);
    chk("ill.retired", 32'(retired), 32'(exp_ret & 16'hFFFF));
`endif

    // Reset asserted during MEM of a load.
    lw = vecs[12];
    opcode = lw.op; funct3 = lw.f3; funct7 = lw.f7; run = 1'b1;
    @(negedge clk); run = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    chk("rstmem.in_mem", 32'(state), 32'd3);
    chk("rstmem.mem_read_pre", 32'(mem_read), 32'd1);
    reset = 1'b1; #1;
    chk("rstmem.state", 32'(state), 32'd0);
    chk("rstmem.mem_read", 32'(mem_read), 32'd0);
    chk("rstmem.retired", 32'(retired), 32'd0);
    chk("rstmem.alu_cc", 32'(alu_cc), 32'h2);
    @(negedge clk); reset = 1'b0; exp_ret = 0; #1;

    // Counter wrap on the 3-bit instance (and continued count on the main one).
    for (int i = 0; i < 9; i++) do_instr(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
